// File: rtl/spawn_scheduler.sv
// spawn_scheduler: paces alien spawn requests to the event core.
// A tick prescaler divides clk_main into 0.1 s ticks, and the spawn interval is
// latched per level. The request is held until the event core acknowledges it.
// Spawning pauses (HOLD) while the live-object count is at or above MAX_OBJECTS.
// Optional macro SPAWN_BURST_EN: issue 1 + cur_level[3:2] back-to-back spawns at
// level entry before normal interval pacing begins.
module spawn_scheduler #(
    parameter int TICK_CYCLES = 39062,
    parameter int MAX_OBJECTS = 8
) (
    input  logic       clk_main,
    input  logic       rst,
    input  logic       en,
    input  logic       level_start,
    input  logic [3:0] cur_level,
    input  logic       script_ended,
    input  logic [3:0] object_count,
    input  logic       spawn_ack,
    output logic       spawn_req,
    output logic [7:0] spawn_count,
    output logic [1:0] sched_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int              PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [4:0]      OBJ_LIMIT = 5'(MAX_OBJECTS);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [5:0]      tcnt_q, tcnt_d;
    logic [5:0]      interval_q, interval_d;
    logic [7:0]      count_q, count_d;
    logic            req_q;
    logic            en_q;
    logic            tick;
    logic            room;
    logic [3:0]      lvl_clamp;
`ifdef SPAWN_BURST_EN
    logic [2:0]      burst_q, burst_d;
`endif

    // The prescaler only runs in WAIT, so every interval is measured in full
    // ticks from the moment WAIT is entered (after a handshake or a restart).
    assign tick      = (state_q == WAIT) && (presc_q == TICK_LAST);
    assign room      = ({1'b0, object_count} < OBJ_LIMIT);
    assign lvl_clamp = (cur_level > 4'd10) ? 4'd10 : cur_level;

    // Next-state, counter and interval logic; level_start beats en, en beats all else.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        interval_d = interval_q;
        count_d    = count_q;
`ifdef SPAWN_BURST_EN
        burst_d    = burst_q;
`endif
        if (state_q != WAIT || level_start || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (level_start) begin
            interval_d = 6'd50 - {lvl_clamp, 2'b00};
            count_d    = '0;
            if (en) begin
`ifdef SPAWN_BURST_EN
                burst_d = 3'd1 + {1'b0, cur_level[3:2]};
                state_d = room ? REQ : HOLD;
`else
                state_d = WAIT;
`endif
            end else begin
`ifdef SPAWN_BURST_EN
                burst_d = '0;
`endif
                state_d = IDLE;
            end
        end else if (!en) begin
`ifdef SPAWN_BURST_EN
            burst_d = '0;
`endif
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!en_q && !script_ended) state_d = WAIT;
                end
                WAIT: begin
                    if (script_ended) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        if (tcnt_q == interval_q - 6'd1) begin
                            tcnt_d  = '0;
                            state_d = room ? REQ : HOLD;
                        end else begin
                            tcnt_d = tcnt_q + 6'd1;
                        end
                    end
                end
                HOLD: begin
                    if (script_ended) begin
`ifdef SPAWN_BURST_EN
                        burst_d = '0;
`endif
                        state_d = IDLE;
                    end else if (room) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (spawn_ack) begin
                        if (count_q != 8'hFF) count_d = count_q + 8'd1;
                        if (script_ended) begin
`ifdef SPAWN_BURST_EN
                            burst_d = '0;
`endif
                            state_d = IDLE;
`ifdef SPAWN_BURST_EN
                        end else if (burst_q > 3'd1) begin
                            burst_d = burst_q - 3'd1;
                            state_d = room ? REQ : HOLD;
                        end else begin
                            burst_d = '0;
                            state_d = WAIT;
`else
                        end else begin
                            state_d = WAIT;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Any exit from WAIT (or restart) leaves the tick counter clean.
        if (state_d != WAIT || level_start) tcnt_d = '0;
    end

    // Control and counter registers; en_q resets high so a level en at reset release is not a rise.
    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            tcnt_q     <= '0;
            interval_q <= 6'd50;
            count_q    <= '0;
            req_q      <= 1'b0;
            en_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tcnt_q     <= tcnt_d;
            interval_q <= interval_d;
            count_q    <= count_d;
            req_q      <= (state_d == REQ);
            en_q       <= en;
        end
    end

`ifdef SPAWN_BURST_EN
    // Remaining level-entry burst handshakes.
    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    assign spawn_req   = req_q;
    assign spawn_count = count_q;
    assign sched_state = state_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Testbench for spawn_scheduler with TICK_CYCLES=4, MAX_OBJECTS=8.
// Expected values are queued when stimulus is applied and popped at observation.
module tb_spawn_scheduler;
    localparam int TICK = 4;
    localparam int MAXO = 8;

    logic       clk_main = 1'b0;
    logic       rst;
    logic       en;
    logic       level_start;
    logic [3:0] cur_level;
    logic       script_ended;
    logic [3:0] object_count;
    logic       spawn_ack;
    logic       spawn_req;
    logic [7:0] spawn_count;
    logic [1:0] sched_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_q[$];
    int exp_v;

    spawn_scheduler #(.TICK_CYCLES(TICK), .MAX_OBJECTS(MAXO)) dut (
        .clk_main     (clk_main),
        .rst          (rst),
        .en           (en),
        .level_start  (level_start),
        .cur_level    (cur_level),
        .script_ended (script_ended),
        .object_count (object_count),
        .spawn_ack    (spawn_ack),
        .spawn_req    (spawn_req),
        .spawn_count  (spawn_count),
        .sched_state  (sched_state)
    );

    always #5 clk_main = ~clk_main;

    task automatic step(input int n);
        repeat (n) @(posedge clk_main);
        #1;
    endtask

    task automatic pulse_level(input logic [3:0] lvl);
        cur_level   = lvl;
        level_start = 1'b1;
        step(1);
        level_start = 1'b0;
    endtask

    task automatic wait_req(input int max, output int n);
        n = 0;
        while (spawn_req !== 1'b1 && n < max) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1; en = 1'b0; level_start = 1'b0; cur_level = 4'd0;
        script_ended = 1'b0; object_count = 4'd0; spawn_ack = 1'b0;
        step(2);
        total_cnt++;
        if (spawn_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", spawn_req); else pass_cnt++;
        total_cnt++;
        if (spawn_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", spawn_count); else pass_cnt++;
        total_cnt++;
        if (sched_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", sched_state); else pass_cnt++;
        en = 1'b1; spawn_ack = 1'b1;
        step(1);
        rst = 1'b0;
        seen = 0;
        repeat (300) begin
            step(1);
            if (spawn_req !== 1'b0) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL post_reset_no_req: got %0d req cycles want 0", seen); else pass_cnt++;
        total_cnt++;
        if (sched_state !== 2'd0) $display("FAIL post_reset_idle: got %0d want 0", sched_state); else pass_cnt++;
    endtask

    task automatic test_level0();
        int n;
        en = 1'b1; spawn_ack = 1'b1; object_count = 4'd0; script_ended = 1'b0;
        exp_q.push_back(200);
        exp_q.push_back(1);
        pulse_level(4'd0);
        total_cnt++;
        if (sched_state !== 2'd1) $display("FAIL level0_wait: got %0d want 1", sched_state); else pass_cnt++;
        wait_req(400, n);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (n !== exp_v) $display("FAIL level0_latency: got %0d want %0d", n, exp_v); else pass_cnt++;
        step(1);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (spawn_count !== 8'(exp_v)) $display("FAIL level0_count: got %0d want %0d", spawn_count, exp_v); else pass_cnt++;
        total_cnt++;
        if (spawn_req !== 1'b0 || sched_state !== 2'd1)
            $display("FAIL level0_after_ack: got req=%0b st=%0d want req=0 st=1", spawn_req, sched_state);
        else pass_cnt++;
    endtask

    task automatic test_interval();
        int n;
        spawn_ack = 1'b1;
        exp_q.push_back(40);
        exp_q.push_back(41);
        exp_q.push_back(41);
        exp_q.push_back(3);
        pulse_level(4'd12);
        wait_req(100, n);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (n !== exp_v) $display("FAIL lvl12_first: got %0d want %0d", n, exp_v); else pass_cnt++;
        for (int g = 0; g < 2; g++) begin
            step(1);
            wait_req(100, n);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (n + 1 !== exp_v) $display("FAIL lvl12_gap%0d: got %0d want %0d", g, n + 1, exp_v); else pass_cnt++;
        end
        step(1);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (spawn_count !== 8'(exp_v)) $display("FAIL lvl12_count: got %0d want %0d", spawn_count, exp_v); else pass_cnt++;
    endtask

    task automatic test_hold();
        int seen;
        object_count = 4'd8; spawn_ack = 1'b1;
        pulse_level(4'd12);
        step(40);
        total_cnt++;
        if (sched_state !== 2'd3 || spawn_req !== 1'b0)
            $display("FAIL hold_enter: got st=%0d req=%0b want st=3 req=0", sched_state, spawn_req);
        else pass_cnt++;
        seen = 0;
        repeat (20) begin
            step(1);
            if (spawn_req !== 1'b0) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL hold_no_req: got %0d req cycles want 0", seen); else pass_cnt++;
        total_cnt++;
        if (sched_state !== 2'd3) $display("FAIL hold_stay: got %0d want 3", sched_state); else pass_cnt++;
        object_count = 4'd7;
        exp_q.push_back(1);
        step(1);
        total_cnt++;
        if (spawn_req !== 1'b1) $display("FAIL hold_release_req: got %0b want 1", spawn_req); else pass_cnt++;
        step(1);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (spawn_count !== 8'(exp_v)) $display("FAIL hold_count: got %0d want %0d", spawn_count, exp_v); else pass_cnt++;
        object_count = 4'd0;
    endtask

    task automatic test_script_end();
        int bad;
        spawn_ack = 1'b0;
        pulse_level(4'd12);
        step(40);
        total_cnt++;
        if (spawn_req !== 1'b1) $display("FAIL se_req_up: got %0b want 1", spawn_req); else pass_cnt++;
        script_ended = 1'b1;
        bad = 0;
        repeat (10) begin
            step(1);
            if (spawn_req !== 1'b1) bad++;
        end
        total_cnt++;
        if (bad !== 0 || sched_state !== 2'd2)
            $display("FAIL se_req_held: got %0d drops st=%0d want 0 drops st=2", bad, sched_state);
        else pass_cnt++;
        spawn_ack = 1'b1;
        exp_q.push_back(1);
        step(1);
        spawn_ack = 1'b0;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (spawn_count !== 8'(exp_v)) $display("FAIL se_count: got %0d want %0d", spawn_count, exp_v); else pass_cnt++;
        total_cnt++;
        if (sched_state !== 2'd0 || spawn_req !== 1'b0)
            $display("FAIL se_idle: got st=%0d req=%0b want st=0 req=0", sched_state, spawn_req);
        else pass_cnt++;
        script_ended = 1'b0;
        step(3);
        total_cnt++;
        if (sched_state !== 2'd0) $display("FAIL se_stay_idle: got %0d want 0", sched_state); else pass_cnt++;
        spawn_ack = 1'b1;
        step(5);
        spawn_ack = 1'b0;
        total_cnt++;
        if (spawn_count !== 8'd1) $display("FAIL ack_ignored_idle: got %0d want 1", spawn_count); else pass_cnt++;
        en = 1'b0;
        step(1);
        en = 1'b1;
        step(1);
        total_cnt++;
        if (sched_state !== 2'd1) $display("FAIL en_rise_wait: got %0d want 1", sched_state); else pass_cnt++;
        spawn_ack = 1'b1;
        step(5);
        spawn_ack = 1'b0;
        total_cnt++;
        if (spawn_count !== 8'd1 || sched_state !== 2'd1)
            $display("FAIL ack_ignored_wait: got cnt=%0d st=%0d want cnt=1 st=1", spawn_count, sched_state);
        else pass_cnt++;
    endtask

    task automatic test_en_drop();
        int n;
        spawn_ack = 1'b1;
        pulse_level(4'd12);
        step(41);
        spawn_ack = 1'b0;
        total_cnt++;
        if (spawn_count !== 8'd1 || sched_state !== 2'd1)
            $display("FAIL endrop_pre: got cnt=%0d st=%0d want cnt=1 st=1", spawn_count, sched_state);
        else pass_cnt++;
        wait_req(100, n);
        total_cnt++;
        if (n !== 40) $display("FAIL endrop_req_wait: got %0d want 40", n); else pass_cnt++;
        en = 1'b0;
        step(1);
        total_cnt++;
        if (spawn_req !== 1'b0 || sched_state !== 2'd0)
            $display("FAIL endrop_idle: got req=%0b st=%0d want req=0 st=0", spawn_req, sched_state);
        else pass_cnt++;
        total_cnt++;
        if (spawn_count !== 8'd1) $display("FAIL endrop_count: got %0d want 1", spawn_count); else pass_cnt++;
        en = 1'b1; spawn_ack = 1'b1;
        pulse_level(4'd12);
        step(41);
        total_cnt++;
        if (spawn_count !== 8'd1 || sched_state !== 2'd1)
            $display("FAIL rst_pre: got cnt=%0d st=%0d want cnt=1 st=1", spawn_count, sched_state);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (spawn_req !== 1'b0 || spawn_count !== 8'd0 || sched_state !== 2'd0)
            $display("FAIL rst_async: got req=%0b cnt=%0d st=%0d want 0 0 0", spawn_req, spawn_count, sched_state);
        else pass_cnt++;
        step(1);
        rst = 1'b0;
        spawn_ack = 1'b0;
    endtask

    task automatic test_burst();
        en = 1'b1; spawn_ack = 1'b1; object_count = 4'd0; script_ended = 1'b0;
        for (int i = 1; i <= 3; i++) exp_q.push_back(i);
        pulse_level(4'd8);
        total_cnt++;
        if (spawn_req !== 1'b1 || sched_state !== 2'd2)
            $display("FAIL burst_start: got req=%0b st=%0d want req=1 st=2", spawn_req, sched_state);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(1);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (spawn_count !== 8'(exp_v)) $display("FAIL burst_count%0d: got %0d want %0d", i, spawn_count, exp_v); else pass_cnt++;
        end
        total_cnt++;
        if (spawn_req !== 1'b0 || sched_state !== 2'd1)
            $display("FAIL burst_end: got req=%0b st=%0d want req=0 st=1", spawn_req, sched_state);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
`ifdef SPAWN_BURST_EN
        test_burst();
`else
        test_level0();
        test_interval();
        test_hold();
        test_script_end();
        test_en_drop();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
